// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable framing, 3-sample majority voting, line-break
// detection and a single-word holding register with overrun signalling.
module uart_rx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);
    localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
    localparam int unsigned   IW        = 4;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SMP_A     = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] SMP_B     = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] SMP_C     = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic [CW-1:0]        cnt;
    logic                 smp_a;
    logic                 smp_b;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 frm_perr;
    logic                 frm_ferr;
    logic                 zero_acc;
    logic                 done;

    logic          maj_c;
    logic          decide_c;
    logic          par_c;
    logic [CW-1:0] cnt_next_c;

    always_comb begin
        maj_c      = (smp_a & smp_b) | (smp_a & rx_sync) | (smp_b & rx_sync);
        decide_c   = (cnt == SMP_C);
        par_c      = (^shreg) ^ maj_c;
        cnt_next_c = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end

    // Synchroniser, bit timing and frame state machine.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            cnt       <= '0;
            smp_a     <= 1'b1;
            smp_b     <= 1'b1;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            frm_perr  <= 1'b0;
            frm_ferr  <= 1'b0;
            zero_acc  <= 1'b0;
            done      <= 1'b0;
            break_det <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            done      <= 1'b0;
            break_det <= 1'b0;
            if (state inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
                cnt <= cnt_next_c;
                if (cnt == SMP_A) smp_a <= rx_sync;
                if (cnt == SMP_B) smp_b <= rx_sync;
            end
            case (state)
                S_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (decide_c) begin
                        if (maj_c) begin
                            state <= S_IDLE;
                        end else begin
                            state    <= S_DATA;
                            bit_idx  <= '0;
                            zero_acc <= 1'b1;
                            frm_perr <= 1'b0;
                            frm_ferr <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (decide_c) begin
                        shreg    <= {maj_c, shreg[DATA_BITS-1:1]};
                        zero_acc <= zero_acc & ~maj_c;
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == LAST_DATA) begin
                            state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            stop_idx <= 1'b0;
                        end
                    end
                end
                S_PARITY: begin
                    if (decide_c) begin
                        frm_perr <= (PARITY == 1) ? ~par_c : par_c;
                        zero_acc <= zero_acc & ~maj_c;
                        state    <= S_STOP;
                        stop_idx <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (decide_c) begin
                        frm_ferr <= frm_ferr | ~maj_c;
                        zero_acc <= zero_acc & ~maj_c;
                        if (stop_idx == LAST_STOP) begin
                            // An all-zero frame is a line break, not a word.
                            if (zero_acc & ~maj_c) begin
                                break_det <= 1'b1;
                                state     <= S_BREAK_WAIT;
                                cnt       <= '0;
                            end else begin
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                S_BREAK_WAIT: begin
                    if (!rx_sync) begin
                        cnt <= '0;
                    end else if (cnt == CNT_MAX) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output holding register: a completed frame loads unless an unconsumed word blocks it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!data_valid || data_ready) begin
                    data       <= shreg;
                    parity_err <= frm_perr;
                    frame_err  <= frm_ferr;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance (u=0) and an 8E1 instance (u=1) driven
// with directed and random frames, checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_l    [2];
    logic       ready   [2];
    logic [7:0] data_o  [2];
    logic       valid_o [2];
    logic       perr_o  [2];
    logic       ferr_o  [2];
    logic       ovr_o   [2];
    logic       brk_o   [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] got_q [$];
    int ovr_cnt [2] = '{0, 0};
    int brk_cnt [2] = '{0, 0};
    int vld_cyc [2] = '{0, 0};

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
        .clk(clk), .rst(rst), .rx(rx_l[0]), .data(data_o[0]), .data_valid(valid_o[0]),
        .data_ready(ready[0]), .parity_err(perr_o[0]), .frame_err(ferr_o[0]),
        .overrun(ovr_o[0]), .break_det(brk_o[0])
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
        .clk(clk), .rst(rst), .rx(rx_l[1]), .data(data_o[1]), .data_valid(valid_o[1]),
        .data_ready(ready[1]), .parity_err(perr_o[1]), .frame_err(ferr_o[1]),
        .overrun(ovr_o[1]), .break_det(brk_o[1])
    );

    // Event observer: transfers, pulses and valid-high cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                if (valid_o[i]) vld_cyc[i]++;
                if (ovr_o[i]) ovr_cnt[i]++;
                if (brk_o[i]) brk_cnt[i]++;
                if (valid_o[i] && ready[i])
                    got_q.push_back({1'(i), data_o[i], perr_o[i], ferr_o[i]});
            end
        end
    end

    task automatic drive_bits(input int u, input logic v, input int clks);
        rx_l[u] = v;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int u, input logic [7:0] d, input logic pbit, input logic stop_v);
        drive_bits(u, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bits(u, d[i], CPB);
        if (u == 1) drive_bits(u, pbit, CPB);
        drive_bits(u, stop_v, CPB);
        rx_l[u] = 1'b1;
    endtask

    // Even-parity bit that makes the total count of ones even.
    function automatic logic even_bit(input logic [7:0] d);
        return 1'($countones(d) % 2);
    endfunction

    // Frame-level expectation: {u, data, parity_err, frame_err}.
    function automatic logic [10:0] model(input int u, input logic [7:0] d, input logic pbit, input logic stop_v);
        logic pe;
        pe = (u == 1) && ((($countones(d) + int'(pbit)) % 2) != 0);
        return {1'(u), d, pe, ~stop_v};
    endfunction

    function automatic bit is_break(input int u, input logic [7:0] d, input logic pbit, input logic stop_v);
        return (d == 8'h00) && (u == 0 || pbit == 1'b0) && (stop_v == 1'b0);
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        rx_l[0] = 1'b1; rx_l[1] = 1'b1;
        ready[0] = 1'b1; ready[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({data_o[i], valid_o[i], perr_o[i], ferr_o[i], ovr_o[i], brk_o[i]} !== 13'h0) begin
                n_fail++;
                $display("FAIL reset_outputs u=%0d: got data=%h v=%b pe=%b fe=%b ov=%b bk=%b, expected all 0",
                         i, data_o[i], valid_o[i], perr_o[i], ferr_o[i], ovr_o[i], brk_o[i]);
            end
        end
        rst = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != 0 || vld_cyc[0] != 0 || vld_cyc[1] != 0) begin
            n_fail++;
            $display("FAIL reset_release_no_start: got %0d words, %0d/%0d valid cycles, expected 0",
                     got_q.size(), vld_cyc[0], vld_cyc[1]);
        end
    endtask

    task automatic test_basic_8n1();
        logic [10:0] exp_w;
        int v0;
        got_q.delete();
        v0 = vld_cyc[0];
        exp_w = model(0, 8'hA5, 1'b0, 1'b1);
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        drive_bits(0, 1'b1, 8);
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++;
            $display("FAIL basic_8n1_count: got %0d words, expected 1", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0] !== exp_w) begin
                n_fail++;
                $display("FAIL basic_8n1_word: got %h, expected %h", got_q[0], exp_w);
            end
        end
        n_checks++;
        if (vld_cyc[0] - v0 != 1) begin
            n_fail++;
            $display("FAIL basic_8n1_valid_len: got %0d cycles, expected 1", vld_cyc[0] - v0);
        end
    endtask

    task automatic test_parity_stop_8e1();
        logic [10:0] exp_q [$];
        got_q.delete();
        exp_q.push_back(model(1, 8'h07, ~even_bit(8'h07), 1'b1));
        send_frame(1, 8'h07, ~even_bit(8'h07), 1'b1);
        drive_bits(1, 1'b1, 10);
        exp_q.push_back(model(1, 8'h3C, even_bit(8'h3C), 1'b0));
        send_frame(1, 8'h3C, even_bit(8'h3C), 1'b0);
        drive_bits(1, 1'b1, 20);
        n_checks++;
        if (got_q.size() != 2) begin
            n_fail++;
            $display("FAIL parity_stop_count: got %0d words, expected 2", got_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (got_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL parity_stop_word%0d: got %h, expected %h", k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_false_start();
        int v0;
        got_q.delete();
        v0 = vld_cyc[0];
        drive_bits(0, 1'b0, 4);
        drive_bits(0, 1'b1, 3 * CPB);
        n_checks++;
        if (vld_cyc[0] != v0 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL false_start_no_valid: got %0d valid cycles, expected 0", vld_cyc[0] - v0);
        end
        send_frame(0, 8'h5A, 1'b0, 1'b1);
        drive_bits(0, 1'b1, 8);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== model(0, 8'h5A, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL false_start_next_frame: got %0d words first=%h, expected 1 word %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 11'h0, model(0, 8'h5A, 1'b0, 1'b1));
        end
    endtask

    task automatic test_overrun();
        int o0;
        got_q.delete();
        o0 = ovr_cnt[0];
        ready[0] = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b1);
        drive_bits(0, 1'b1, 6);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        drive_bits(0, 1'b1, 6);
        n_checks++;
        if (data_o[0] !== 8'h11 || valid_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_hold: got data=%h v=%b, expected data=11 v=1", data_o[0], valid_o[0]);
        end
        n_checks++;
        if (ovr_cnt[0] - o0 != 1) begin
            n_fail++;
            $display("FAIL overrun_pulse: got %0d pulses, expected 1", ovr_cnt[0] - o0);
        end
        ready[0] = 1'b1;
        drive_bits(0, 1'b1, 3 * CPB);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== model(0, 8'h11, 1'b0, 1'b1) || valid_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_drain: got %0d words first=%h v=%b, expected one word %h and v=0",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 11'h0, valid_o[0], model(0, 8'h11, 1'b0, 1'b1));
        end
    endtask

    task automatic test_break();
        int b0;
        int v0;
        got_q.delete();
        b0 = brk_cnt[0];
        v0 = vld_cyc[0];
        drive_bits(0, 1'b0, 15 * CPB);
        drive_bits(0, 1'b1, 3 * CPB);
        n_checks++;
        if (brk_cnt[0] - b0 != 1) begin
            n_fail++;
            $display("FAIL break_pulse: got %0d pulses, expected 1", brk_cnt[0] - b0);
        end
        n_checks++;
        if (vld_cyc[0] != v0) begin
            n_fail++;
            $display("FAIL break_no_valid: got %0d valid cycles, expected 0", vld_cyc[0] - v0);
        end
        send_frame(0, 8'h81, 1'b0, 1'b1);
        drive_bits(0, 1'b1, 8);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== model(0, 8'h81, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL break_next_frame: got %0d words first=%h, expected %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 11'h0, model(0, 8'h81, 1'b0, 1'b1));
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        int v0;
        int o0;
        int b0;
        d = 8'hC3;
        drive_bits(0, 1'b0, CPB);
        for (int i = 0; i < 3; i++) drive_bits(0, d[i], CPB);
        drive_bits(0, d[3], CPB / 2);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({data_o[0], valid_o[0], perr_o[0], ferr_o[0], ovr_o[0], brk_o[0]} !== 13'h0) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: got data=%h v=%b pe=%b fe=%b ov=%b bk=%b, expected all 0",
                     data_o[0], valid_o[0], perr_o[0], ferr_o[0], ovr_o[0], brk_o[0]);
        end
        repeat (3) @(posedge clk);
        #1;
        rx_l[0] = 1'b1;
        rst = 1'b1;
        got_q.delete();
        v0 = vld_cyc[0]; o0 = ovr_cnt[0]; b0 = brk_cnt[0];
        drive_bits(0, 1'b1, 12 * CPB);
        n_checks++;
        if (vld_cyc[0] != v0 || ovr_cnt[0] != o0 || brk_cnt[0] != b0) begin
            n_fail++;
            $display("FAIL midframe_abort: got v=%0d ov=%0d bk=%0d events, expected 0",
                     vld_cyc[0] - v0, ovr_cnt[0] - o0, brk_cnt[0] - b0);
        end
        send_frame(0, d, 1'b0, 1'b1);
        drive_bits(0, 1'b1, 8);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== model(0, d, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL midframe_next_frame: got %0d words first=%h, expected %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 11'h0, model(0, d, 1'b0, 1'b1));
        end
    endtask

    // Random words, parity corruption and stop errors; gap 0 exercises back-to-back frames.
    task automatic test_random(input int u, input int n, input bit back_to_back);
        logic [10:0] exp_q [$];
        logic [7:0]  d;
        logic        pbit;
        logic        stop_v;
        got_q.delete();
        for (int k = 0; k < n; k++) begin
            d      = 8'($urandom);
            pbit   = even_bit(d) ^ ((u == 1) && ($urandom_range(0, 2) == 0));
            stop_v = back_to_back ? 1'b1 : ($urandom_range(0, 4) != 0);
            if (is_break(u, d, pbit, stop_v)) stop_v = 1'b1;
            exp_q.push_back(model(u, d, pbit, stop_v));
            send_frame(u, d, pbit, stop_v);
            if (!back_to_back) drive_bits(u, 1'b1, $urandom_range(4, 30));
        end
        drive_bits(u, 1'b1, 2 * CPB);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random_u%0d_count: got %0d words, expected %0d", u, got_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if (got_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL random_u%0d_word%0d: got %h, expected %h", u, k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity_stop_8e1();
        test_false_start();
        test_overrun();
        test_break();
        test_reset_midframe();
        test_random(0, 8, 1'b0);
        test_random(1, 10, 1'b0);
        test_random(0, 5, 1'b1);
        test_random(1, 5, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
